alu_execute_unit: RTL
=====================

# alu_execute_unit

Execute-stage ALU that consumes the 4-bit operation code from the ALU control decoder plus two 32-bit operands and produces a registered result with zero/overflow flags. Single-cycle ops (ADD, SUB, OR, AND, LUI) complete in one cycle at full throughput. MUL runs as an iterative 32-cycle shift-add sequence behind a ready/valid handshake. Sits between register-file/immediate operand selection and the write-back mux.

## Interface
- `DATA_WIDTH`, default 32: operand and result width. Fixed at 32; the multiplier iteration count equals `DATA_WIDTH`.
- `clk_i`, input, 1: clock. All state updates on the rising edge.
- `rst_i`, input, 1: reset. **One clock; reset is synchronous and active-high.**
- `start_i`, input, 1: request. Accepted only when `ready_o`=1.
- `alu_operation_i`, input, 4: operation code. 0011 ADD, 0100 SUB, 0010 OR, 0110 AND, 0101 LUI, 0111 MUL; all other codes are illegal, including the decoder's default 1001.
- `a_data_i`, input, 32: operand A (rs).
- `b_data_i`, input, 32: operand B (rt or extended immediate).
- `ready_o`, output, 1: unit idle, can accept `start_i`.
- `valid_o`, output, 1: one-cycle pulse; `result_o` and the flags are updated this cycle.
- `result_o`, output, 32: registered result. Holds its value until the next completion.
- `zero_o`, output, 1: `result_o` == 0. Registered with the result.
- `overflow_o`, output, 1: signed overflow, ADD/SUB only. 0 for all other ops.
- `illegal_o`, output, 1: the completing op had an illegal code. Registered with the result.

## Operation
- **States:** IDLE, MUL.
- **IDLE:** `ready_o`=1.
  - `start_i`=1 with a single-cycle op: compute, register the result and flags, `valid_o`=1 next cycle, stay in IDLE.
  - `start_i`=1 with MUL: latch A into the multiplicand register and B into the multiplier register, clear the accumulator and the 5-bit counter, go to MUL.
- **MUL:** `ready_o`=0.
  - Each cycle: if the multiplier LSB is 1, add the multiplicand to the accumulator; shift the multiplicand left by 1 and the multiplier right by 1; increment the counter.
  - On the cycle counter==31 (32nd iteration): register the final accumulator as the result, `valid_o`=1, return to IDLE.
- **Arithmetic:**
  - ADD/SUB: 32-bit wrap-around. `overflow_o` = operand signs equal (for SUB, A and ~B) and result sign differs.
  - LUI: {B[15:0], 16'h0000}.
  - MUL: low 32 bits of A×B, which is identical for signed and unsigned operands. No overflow flag.
  - Illegal code: `result_o`=0, `zero_o`=1, `illegal_o`=1, `valid_o` still pulses. The unit never hangs.
- **Boundary conditions:**
  - `start_i` while `ready_o`=0 is ignored and not queued.
  - Operand/op changes during MUL have no effect.
  - `rst_i` mid-MUL aborts the operation: no `valid_o` is produced, and `ready_o`=1 the cycle after reset.
- **Reset values:** state IDLE, `ready_o`=1, `valid_o`=0, `result_o`=0, `zero_o`=1, `overflow_o`=0, `illegal_o`=0, counter 0.

## Timing
- Single-cycle ops: `start_i` sampled at edge N, `valid_o`/`result_o` visible after edge N. Latency 1 cycle. Back-to-back starts every cycle give one result per cycle.
- MUL: `start_i` sampled at edge N, iterations at edges N+1…N+32, `valid_o` visible after edge N+32. Latency 32 cycles.
- `ready_o` is low for exactly the 32 MUL cycles. A new start is accepted in the same cycle that `valid_o` is high.
- `valid_o` is never high for two cycles from one request.
- `ready_o` is combinational from the state only, with no path from `start_i`.

## Structure
- Package `alu_pkg`, shared with the ALU control decoder:
  - 4-bit operation-code localparams, including the new `ALU_MUL`=4'b0111; the decoder gains that code.
  - State encoding.
  - `DATA_WIDTH`.
- Sub-module `shift_add_multiplier`: multiplicand/multiplier/accumulator registers, counter, `load`/`done` interface. The top level holds the FSM, the single-cycle datapath and the output registers.

## Test plan
- ADD A=5, B=7 -> after 1 cycle `valid_o`=1, `result_o`=12, `zero_o`=0, `overflow_o`=0.
- SUB A=3, B=3 -> `result_o`=0, `zero_o`=1. Then ADD A=0x7FFFFFFF, B=1 -> `result_o`=0x80000000, `overflow_o`=1.
- LUI B=0x00001234 -> `result_o`=0x12340000. Then OR, AND, ADD, SUB back-to-back on 4 consecutive cycles -> 4 consecutive `valid_o` pulses with correct results.
- MUL A=6, B=7 -> `ready_o`=0 for 32 cycles, then `valid_o`=1 with `result_o`=42. An ADD `start_i` issued mid-MUL produces no result. MUL A=0xFFFFFFFF, B=2 -> `result_o`=0xFFFFFFFE.
- MUL started, `rst_i` asserted at iteration 10 -> no `valid_o`, `ready_o`=1 the next cycle, `result_o`=0.
- Op 1001 with A=1, B=1 -> `valid_o`=1, `result_o`=0, `illegal_o`=1. The next legal ADD clears `illegal_o`.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control decoder and the execute-stage ALU:
// operation codes, FSM state encoding and datapath width.
package alu_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [3:0] ALU_OR      = 4'b0010;
  localparam logic [3:0] ALU_ADD     = 4'b0011;
  localparam logic [3:0] ALU_SUB     = 4'b0100;
  localparam logic [3:0] ALU_LUI     = 4'b0101;
  localparam logic [3:0] ALU_AND     = 4'b0110;
  localparam logic [3:0] ALU_MUL     = 4'b0111;
  localparam logic [3:0] ALU_DEFAULT = 4'b1001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_execute_unit_if.sv
// Request/response bundle between operand selection, the execute ALU and write-back.
interface alu_execute_unit_if #(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
);
  logic                  start_i;
  logic [3:0]            alu_operation_i;
  logic [DATA_WIDTH-1:0] a_data_i;
  logic [DATA_WIDTH-1:0] b_data_i;
  logic                  ready_o;
  logic                  valid_o;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  zero_o;
  logic                  overflow_o;
  logic                  illegal_o;

  modport master (
    output start_i, alu_operation_i, a_data_i, b_data_i,
    input  ready_o, valid_o, result_o, zero_o, overflow_o, illegal_o
  );

  modport slave (
    input  start_i, alu_operation_i, a_data_i, b_data_i,
    output ready_o, valid_o, result_o, zero_o, overflow_o, illegal_o
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Iterative shift-add multiplier: one partial-product step per cycle, WIDTH steps.
// done_o flags the final step; product_o then carries the completed low-half product.
module shift_add_multiplier #(
  parameter int WIDTH = alu_pkg::DATA_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);
  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o    = busy_q && (cnt_q == LAST);
  // Expose the accumulator including the current step so the last add is not lost.
  assign product_o = acc_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (load_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        busy_q <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/alu_execute_unit.sv
// Execute-stage ALU: single-cycle ADD/SUB/OR/AND/LUI, iterative MUL, registered
// result with zero/overflow/illegal flags and a one-cycle valid pulse.
module alu_execute_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  alu_execute_unit_if.slave  bus
);
  alu_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;
  logic                  ovf_q, ovf_d;
  logic                  ill_q, ill_d;
  logic                  valid_q, valid_d;

  logic [DATA_WIDTH-1:0] sum, diff, alu_res;
  logic                  alu_ovf, alu_ill;
  logic                  mul_load, mul_done;
  logic [DATA_WIDTH-1:0] mul_product;

  shift_add_multiplier #(.WIDTH(DATA_WIDTH)) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (mul_load),
    .a_i       (bus.a_data_i),
    .b_i       (bus.b_data_i),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  assign sum  = bus.a_data_i + bus.b_data_i;
  assign diff = bus.a_data_i - bus.b_data_i;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (bus.alu_operation_i)
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.a_data_i[DATA_WIDTH-1] == bus.b_data_i[DATA_WIDTH-1]) &&
                  (sum[DATA_WIDTH-1] != bus.a_data_i[DATA_WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = (bus.a_data_i[DATA_WIDTH-1] != bus.b_data_i[DATA_WIDTH-1]) &&
                  (diff[DATA_WIDTH-1] != bus.a_data_i[DATA_WIDTH-1]);
      end
      ALU_OR:  alu_res = bus.a_data_i | bus.b_data_i;
      ALU_AND: alu_res = bus.a_data_i & bus.b_data_i;
      ALU_LUI: alu_res = {bus.b_data_i[15:0], {(DATA_WIDTH-16){1'b0}}};
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    valid_d  = 1'b0;
    mul_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          if (bus.alu_operation_i == ALU_MUL) begin
            mul_load = 1'b1;
            state_d  = ST_MUL;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            ill_d    = alu_ill;
            valid_d  = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          result_d = mul_product;
          zero_d   = (mul_product == '0);
          ovf_d    = 1'b0;
          ill_d    = 1'b0;
          valid_d  = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
      valid_q  <= valid_d;
    end
  end

  // Ready depends on state alone so upstream never sees a start-to-ready loop.
  assign bus.ready_o    = (state_q == ST_IDLE);
  assign bus.valid_o    = valid_q;
  assign bus.result_o   = result_q;
  assign bus.zero_o     = zero_q;
  assign bus.overflow_o = ovf_q;
  assign bus.illegal_o  = ill_q;
endmodule
